// File: rtl/ofdm_pkg.sv
// Shared OFDM types and beat packing, used by both the transmit framer
// and the receive-side decoder so the tdata layout is identical in both directions.
package ofdm_pkg;

    localparam int N_SC  = 8;
    localparam int DW    = 20;
    localparam int TDW   = 48;
    localparam int IDX_W = $clog2(N_SC);

    typedef logic signed [DW-1:0] sym_t;
    typedef sym_t [N_SC-1:0]      frame_t;

    typedef enum logic {
        RD_IDLE,
        RD_SEND
    } rd_state_e;

    // One AXI-Stream beat: imag in the upper half, real in the lower half,
    // each sign-extended to half the bus width, no scaling or rounding.
    function automatic logic [TDW-1:0] pack_beat(input sym_t re, input sym_t im);
        logic [TDW/2-1:0] re_x;
        logic [TDW/2-1:0] im_x;
        re_x = {{(TDW/2-DW){re[DW-1]}}, re};
        im_x = {{(TDW/2-DW){im[DW-1]}}, im};
        return {im_x, re_x};
    endfunction

endpackage

// File: rtl/pa2se_if.sv
// AXI-Stream link from the framer into the IFFT core's data slave port.
interface pa2se_if;
    import ofdm_pkg::*;

    logic [TDW-1:0]   tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic [IDX_W-1:0] tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/frame_pingpong.sv
// Two-slot ping-pong frame store: the writer fills one slot while the reader
// drains the other, so consecutive frames can stream without a gap.
module frame_pingpong
    import ofdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  frame_t     wr_re,
    input  frame_t     wr_im,
    input  logic       rd_done,
    output frame_t     rd_re,
    output frame_t     rd_im,
    output logic [1:0] fill,
    output logic       wr_ready
);

    frame_t     slot_re_q [2];
    frame_t     slot_re_d [2];
    frame_t     slot_im_q [2];
    frame_t     slot_im_d [2];
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic [1:0] fill_q, fill_d;

    // Slot write: an accepted frame lands in the slot the write pointer names.
    always_comb begin
        slot_re_d = slot_re_q;
        slot_im_d = slot_im_q;
        if (wr_en) begin
            slot_re_d[wr_sel_q] = wr_re;
            slot_im_d[wr_sel_q] = wr_im;
        end
    end

    // Pointer and occupancy update; a write and a release in the same cycle leave fill as is.
    always_comb begin
        wr_sel_d = wr_sel_q ^ wr_en;
        rd_sel_d = rd_sel_q ^ rd_done;
        fill_d   = fill_q;
        case ({wr_en, rd_done})
            2'b10:   fill_d = fill_q + 2'd1;
            2'b01:   fill_d = fill_q - 2'd1;
            default: fill_d = fill_q;
        endcase
    end

    // Control state register; reset drops any buffered frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            fill_q   <= 2'd0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            fill_q   <= fill_d;
        end
    end

    // Slot storage is data only and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        slot_re_q <= slot_re_d;
        slot_im_q <= slot_im_d;
    end

    assign rd_re    = slot_re_q[rd_sel_q];
    assign rd_im    = slot_im_q[rd_sel_q];
    assign fill     = fill_q;
    assign wr_ready = (fill_q != 2'd2);

endmodule

// File: rtl/pa2se.sv
// Parallel-to-serial framer: buffers whole subcarrier frames and streams
// them one symbol per beat into the IFFT core, tlast on the final subcarrier.
module pa2se
    import ofdm_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  frame_t  tx_sig_real,
    input  frame_t  tx_sig_imag,
    input  logic    tx_valid,
    output logic    tx_ready,
    output logic    frame_drop,
    pa2se_if.master ifft_s_data
);

    rd_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             accept;
    logic             frame_done;
    frame_t           rd_re;
    frame_t           rd_im;
    logic [1:0]       fill;
    logic [TDW-1:0]   tdata;
    logic             tvalid;
    logic             tlast;
    logic [IDX_W-1:0] tuser;

    assign accept     = tx_valid && tx_ready;
    assign frame_drop = tx_valid && !tx_ready;

    frame_pingpong u_store (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .wr_re    (tx_sig_real),
        .wr_im    (tx_sig_imag),
        .rd_done  (frame_done),
        .rd_re    (rd_re),
        .rd_im    (rd_im),
        .fill     (fill),
        .wr_ready (tx_ready)
    );

    // Read FSM: present the current slot's symbol, advance on each handshake,
    // and release the slot after the last subcarrier.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_done = 1'b0;
        tvalid     = 1'b0;
        tlast      = 1'b0;
        tuser      = '0;
        tdata      = '0;
        case (state_q)
            RD_IDLE: begin
                if (accept) state_d = RD_SEND;
            end
            RD_SEND: begin
                tvalid = 1'b1;
                tuser  = idx_q;
                tlast  = (idx_q == IDX_W'(N_SC - 1));
                tdata  = pack_beat(rd_re[idx_q], rd_im[idx_q]);
                if (ifft_s_data.tready) begin
                    if (tlast) begin
                        idx_d      = '0;
                        frame_done = 1'b1;
                        if (fill == 2'd1 && !accept) state_d = RD_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // FSM state and beat index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RD_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign ifft_s_data.tdata  = tdata;
    assign ifft_s_data.tvalid = tvalid;
    assign ifft_s_data.tlast  = tlast;
    assign ifft_s_data.tuser  = tuser;

endmodule

// File: tb/tb_pa2se.sv
// Directed bench for pa2se: every cycle the outputs are compared against a
// beat queue and occupancy model, with hand-computed constants at key points.
module tb_pa2se;
    import ofdm_pkg::*;

    typedef struct {
        logic [47:0] data;
        logic [2:0]  user;
        logic        last;
    } beat_t;

    logic   clk;
    logic   rst;
    frame_t re_in;
    frame_t im_in;
    logic   tx_valid;
    logic   tx_ready;
    logic   frame_drop;

    pa2se_if axis ();

    pa2se dut (
        .clk         (clk),
        .rst         (rst),
        .tx_sig_real (re_in),
        .tx_sig_imag (im_in),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .frame_drop  (frame_drop),
        .ifft_s_data (axis)
    );

    int    tests_run;
    int    tests_failed;
    int    model_fill;
    beat_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected beats of one frame, packed straight from the bus layout.
    task automatic pushFrame(input frame_t re, input frame_t im);
        beat_t b;
        for (int k = 0; k < 8; k++) begin
            b.data = {{4{im[k][19]}}, im[k], {4{re[k][19]}}, re[k]};
            b.user = 3'(k);
            b.last = (k == 7);
            exp_q.push_back(b);
        end
    endtask

    // One clock cycle: drive inputs after the edge, check outputs, then
    // advance the model by what the next edge will do.
    task automatic applyStimulus(input logic v, input frame_t re, input frame_t im, input logic rdy);
        logic acc;
        logic done;
        @(posedge clk);
        #1;
        tx_valid    = v;
        re_in       = re;
        im_in       = im;
        axis.tready = rdy;
        #1;
        checkOutput("tx_ready", 64'(tx_ready), 64'(model_fill != 2));
        checkOutput("frame_drop", 64'(frame_drop), 64'(v && model_fill == 2));
        checkOutput("tvalid", 64'(axis.tvalid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            checkOutput("tdata", 64'(axis.tdata), 64'(exp_q[0].data));
            checkOutput("tuser", 64'(axis.tuser), 64'(exp_q[0].user));
            checkOutput("tlast", 64'(axis.tlast), 64'(exp_q[0].last));
        end
        acc  = v && (model_fill != 2);
        done = 1'b0;
        if (exp_q.size() != 0 && rdy) begin
            done = exp_q[0].last;
            void'(exp_q.pop_front());
        end
        if (acc) pushFrame(re, im);
        model_fill = model_fill + int'(acc) - int'(done);
    endtask

    // Reset asserted for the coming edge, then the idle state is checked.
    task automatic doReset();
        rst      = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_fill = 0;
        #1;
        checkOutput("rst_tvalid", 64'(axis.tvalid), 64'd0);
        checkOutput("rst_tlast", 64'(axis.tlast), 64'd0);
        checkOutput("rst_tuser", 64'(axis.tuser), 64'd0);
        checkOutput("rst_tdata", 64'(axis.tdata), 64'd0);
        checkOutput("rst_tx_ready", 64'(tx_ready), 64'd1);
        checkOutput("rst_frame_drop", 64'(frame_drop), 64'd0);
    endtask

    frame_t ramp_re, ramp_im, sx_re, sx_im, rnd_re, rnd_im, zero_f;
    logic   v;
    int     sent;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_fill   = 0;
        rst          = 1'b1;
        tx_valid     = 1'b0;
        axis.tready  = 1'b0;
        zero_f       = '0;
        re_in        = '0;
        im_in        = '0;
        for (int k = 0; k < 8; k++) begin
            ramp_re[k] = 20'(k + 1);
            ramp_im[k] = 20'(-(k + 1));
        end
        sx_re    = ramp_re;
        sx_im    = ramp_im;
        sx_re[3] = 20'h80000;
        sx_im[3] = 20'h7FFFF;

        @(posedge clk);
        doReset();

        // Single frame with constant beat checks.
        applyStimulus(1'b1, ramp_re, ramp_im, 1'b1);
        applyStimulus(1'b0, zero_f, zero_f, 1'b1);
        checkOutput("single_beat0", 64'(axis.tdata), 64'h0000_FFFF_FF00_0001);
        for (int c = 0; c < 7; c++) applyStimulus(1'b0, zero_f, zero_f, 1'b1);
        checkOutput("single_last", 64'(axis.tlast), 64'd1);
        applyStimulus(1'b0, zero_f, zero_f, 1'b1);

        // Sign extension on subcarrier 3.
        applyStimulus(1'b1, sx_re, sx_im, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, zero_f, zero_f, 1'b1);
        checkOutput("sext_tuser", 64'(axis.tuser), 64'd3);
        checkOutput("sext_beat3", 64'(axis.tdata), 64'h0000_07FF_FFF8_0000);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, zero_f, zero_f, 1'b1);

        // Back-to-back frames stream gaplessly.
        applyStimulus(1'b1, ramp_re, ramp_im, 1'b1);
        applyStimulus(1'b1, sx_re, sx_im, 1'b1);
        for (int c = 0; c < 17; c++) applyStimulus(1'b0, zero_f, zero_f, 1'b1);

        // Backpressure: two frames fit, the third is dropped.
        applyStimulus(1'b1, ramp_re, ramp_im, 1'b0);
        applyStimulus(1'b1, sx_re, sx_im, 1'b0);
        applyStimulus(1'b1, ramp_re, ramp_im, 1'b0);
        checkOutput("bp_drop", 64'(frame_drop), 64'd1);
        checkOutput("bp_not_ready", 64'(tx_ready), 64'd0);
        for (int c = 0; c < 17; c++) applyStimulus(1'b0, zero_f, zero_f, 1'b0);
        checkOutput("bp_hold_beat0", 64'(axis.tdata), 64'h0000_FFFF_FF00_0001);
        for (int c = 0; c < 18; c++) applyStimulus(1'b0, zero_f, zero_f, 1'b1);

        // Random backpressure over 100 frames.
        sent = 0;
        for (int c = 0; c < 4000 && sent < 100; c++) begin
            v = (model_fill != 2);
            for (int k = 0; k < 8; k++) begin
                rnd_re[k] = 20'($urandom);
                rnd_im[k] = 20'($urandom);
            end
            applyStimulus(v, rnd_re, rnd_im, 1'($urandom_range(0, 1)));
            if (v) sent++;
        end
        checkOutput("rand_frames_sent", 64'(sent), 64'd100);
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) applyStimulus(1'b0, zero_f, zero_f, 1'b1);
        checkOutput("rand_drained", 64'(exp_q.size()), 64'd0);

        // Reset while beat 4 is on the bus.
        applyStimulus(1'b1, sx_re, sx_im, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, zero_f, zero_f, 1'b1);
        checkOutput("midrst_tuser4", 64'(axis.tuser), 64'd4);
        doReset();
        applyStimulus(1'b1, ramp_re, ramp_im, 1'b1);
        applyStimulus(1'b0, zero_f, zero_f, 1'b1);
        checkOutput("midrst_restart_tuser", 64'(axis.tuser), 64'd0);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, zero_f, zero_f, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
